wav_mcu_dtcm_arb: RTL and testbench
===================================

Name: wav_mcu_dtcm_arb

Overview:
- Two-port arbiter sharing the single-port MCU DTCM SRAM between the Ibex data port ("core") and the external host/debug bus ("host").
- Sits between the MCU interconnect and the DTCM macro.
- OBI-style req/gnt/rvalid handshake on both requesters.
- Round-robin arbitration, address range checking, and one-cycle pipelined responses.

Parameters:
- BASE, 32'h00050000, DTCM byte base address; must be aligned to SIZE.
- SIZE, 65536, DTCM size in bytes; must be a power of two, at least 8.
- AWIDTH, 32, requester address width.
- DWIDTH, 32, data width (fixed at 32; BE width 4).
- MAWIDTH, $clog2(SIZE)-2, SRAM word-address width (14 at default).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_core_req  in  1  core request
- i_core_we  in  1  core write enable
- i_core_be  in  4  core byte enables
- i_core_addr  in  AWIDTH  core byte address
- i_core_wdata  in  32  core write data
- o_core_gnt  out  1  core grant (combinational)
- o_core_rvalid  out  1  core response valid
- o_core_rdata  out  32  core read data
- o_core_err  out  1  core response error
- i_host_req, i_host_we, i_host_be, i_host_addr, i_host_wdata  in  1/1/4/AWIDTH/32  host request, same meaning as core
- o_host_gnt, o_host_rvalid, o_host_rdata, o_host_err  out  1/1/32/1  host response, same meaning as core
- o_mem_cs  out  1  SRAM chip select
- o_mem_we  out  1  SRAM write enable
- o_mem_be  out  4  SRAM byte enables
- o_mem_addr  out  MAWIDTH  SRAM word address
- o_mem_wdata  out  32  SRAM write data
- i_mem_rdata  in  32  SRAM read data, valid the cycle after cs
- o_conflict_cnt  out  16  conflict counter (see Optional Feature)
- i_cnt_clr  in  1  synchronous counter clear

Behaviour:
- Grant:
  - Combinational in the same cycle as req.
  - At most one gnt per cycle.
  - A new grant is allowed every cycle (fully pipelined).
- Arbitration:
  - Single requester: granted immediately.
  - Both requesting: grant the requester not granted last. A 1-bit last-grant pointer updates on every grant.
  - Pointer reset value selects core first.
- Address check:
  - In range iff BASE <= addr < BASE+SIZE.
  - o_mem_addr = addr[MAWIDTH+1:2]; the low 2 bits are ignored.
- Granted in-range access:
  - o_mem_cs=1; we/be/wdata pass through from the winner in the same cycle.
- Granted out-of-range access:
  - o_mem_cs=0; the request is recorded as an error.
- Response:
  - Registered rsp_valid, rsp_owner, rsp_err.
  - Exactly one cycle after gnt, the owner's rvalid=1 for both reads and writes.
  - rdata = i_mem_rdata for an in-range read; 32'h0 for writes and errors.
  - err=1 only for out-of-range.
  - The non-owner's rvalid=0 and its rdata=0.
- Back-to-back: the grant in cycle N+1 coexists with the response for cycle N. No bubble.
- Requester rule: req and the request fields stay stable until gnt. The arbiter may hold off the loser indefinitely only while the other side keeps winning; round-robin bounds the wait to 1 grant.
- Reset values: all outputs 0; rsp_valid=0; pointer=core-first; counter=0.
- Reset mid-operation (async assertion): any outstanding response is dropped with no rvalid after release; mem_cs drops immediately.
- Idle (no req): mem_cs=0; mem_addr/we/be/wdata driven 0.

Optional Feature:
- Macro: WAV_MCU_DTCM_ARB_CNT_EN.
- Defined:
  - o_conflict_cnt increments by 1 every cycle in which both i_core_req and i_host_req are high.
  - Saturates at 16'hFFFF.
  - i_cnt_clr zeroes it; clear has priority over increment.
- Undefined: o_conflict_cnt tied to 16'h0; i_cnt_clr ignored; no counter flops.

Test Plan:
- Core write 32'h00050010 data 32'hDEADBEEF be=4'hF, then read the same address. Required: gnt the same cycle, mem_addr=14'h4, mem_we=1; on the read, core_rvalid 1 cycle later with rdata=32'hDEADBEEF, err=0.
- Core and host both hold read requests for 4 cycles from reset. Required: grants alternate core, host, core, host; responses go to the correct owner each following cycle; conflict_cnt=4 with CNT_EN defined, 0 without.
- Host read at 32'h00060000 (out of range). Required: host_gnt=1, mem_cs=0, next cycle host_rvalid=1, err=1, rdata=0.
- Back-to-back core reads on 3 consecutive cycles to 0x50000/0x50004/0x50008. Required: rvalid on 3 consecutive cycles with correct data, no bubble.
- Assert i_rst_n low in the cycle after a granted host read. Required: no host_rvalid ever appears; after release, the pointer favors core when both request.
- With CNT_EN defined, force 70000 conflict cycles. Required: counter holds 16'hFFFF; pulse i_cnt_clr during a conflict cycle, counter becomes 0.

Source files
------------

// File: rtl/wav_mcu_dtcm_arb.sv
// wav_mcu_dtcm_arb: shares the single-port MCU DTCM SRAM between the Ibex
// data port (core) and the external host/debug bus (host).
// Both requesters use an OBI-style req/gnt/rvalid handshake. Grants are
// combinational and round-robin, out-of-range accesses are answered with
// an error response, and every response arrives exactly one cycle after
// its grant.
// Optional feature: define WAV_MCU_DTCM_ARB_CNT_EN to build the saturating
// conflict counter; without it o_conflict_cnt is tied to zero.
module wav_mcu_dtcm_arb #(
  parameter logic [31:0] BASE    = 32'h00050000,
  parameter int          SIZE    = 65536,
  parameter int          AWIDTH  = 32,
  parameter int          DWIDTH  = 32,
  parameter int          MAWIDTH = $clog2(SIZE) - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_core_req,
  input  logic                  i_core_we,
  input  logic [DWIDTH/8-1:0]   i_core_be,
  input  logic [AWIDTH-1:0]     i_core_addr,
  input  logic [DWIDTH-1:0]     i_core_wdata,
  output logic                  o_core_gnt,
  output logic                  o_core_rvalid,
  output logic [DWIDTH-1:0]     o_core_rdata,
  output logic                  o_core_err,
  input  logic                  i_host_req,
  input  logic                  i_host_we,
  input  logic [DWIDTH/8-1:0]   i_host_be,
  input  logic [AWIDTH-1:0]     i_host_addr,
  input  logic [DWIDTH-1:0]     i_host_wdata,
  output logic                  o_host_gnt,
  output logic                  o_host_rvalid,
  output logic [DWIDTH-1:0]     o_host_rdata,
  output logic                  o_host_err,
  output logic                  o_mem_cs,
  output logic                  o_mem_we,
  output logic [DWIDTH/8-1:0]   o_mem_be,
  output logic [MAWIDTH-1:0]    o_mem_addr,
  output logic [DWIDTH-1:0]     o_mem_wdata,
  input  logic [DWIDTH-1:0]     i_mem_rdata,
  output logic [15:0]           o_conflict_cnt,
  input  logic                  i_cnt_clr
);

  // Number of byte-offset bits inside the DTCM window.
  localparam int OFFW = $clog2(SIZE);
  localparam logic [AWIDTH-1:0] BASE_A = AWIDTH'(BASE);

  logic                core_in_range;
  logic                host_in_range;
  logic                core_win;
  logic                host_win;
  logic                any_gnt;
  logic                last_host;
  logic                win_we;
  logic                win_in_range;
  logic [DWIDTH/8-1:0] win_be;
  logic [AWIDTH-1:0]   win_addr;
  logic [DWIDTH-1:0]   win_wdata;
  logic                mem_sel;
  logic                rsp_valid;
  logic                rsp_owner;
  logic                rsp_err;
  logic                rsp_read;
  logic [DWIDTH-1:0]   rsp_data;
  logic                unused_addr_bits;

  // BASE is SIZE-aligned, so the range check reduces to comparing the
  // address bits above the window offset with those of BASE.
  always_comb begin
    core_in_range = (i_core_addr[AWIDTH-1:OFFW] == BASE_A[AWIDTH-1:OFFW]);
    host_in_range = (i_host_addr[AWIDTH-1:OFFW] == BASE_A[AWIDTH-1:OFFW]);
  end

  // Round-robin choice: on a conflict the side not granted last wins.
  // Grants are masked while reset is asserted so the SRAM is released at once.
  always_comb begin
    core_win = i_rst_n & i_core_req & (~i_host_req | last_host);
    host_win = i_rst_n & i_host_req & (~i_core_req | ~last_host);
    any_gnt  = core_win | host_win;
  end

  assign o_core_gnt = core_win;
  assign o_host_gnt = host_win;

  // Steer the winning requester's fields towards the SRAM.
  always_comb begin
    if (host_win) begin
      win_we       = i_host_we;
      win_be       = i_host_be;
      win_addr     = i_host_addr;
      win_wdata    = i_host_wdata;
      win_in_range = host_in_range;
    end else begin
      win_we       = i_core_we;
      win_be       = i_core_be;
      win_addr     = i_core_addr;
      win_wdata    = i_core_wdata;
      win_in_range = core_in_range;
    end
  end

  assign mem_sel = any_gnt & win_in_range;

  // SRAM bus is all-zero unless a granted in-range access is in flight.
  always_comb begin
    o_mem_cs    = mem_sel;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (mem_sel) begin
      o_mem_we    = win_we;
      o_mem_be    = win_be;
      o_mem_addr  = win_addr[MAWIDTH+1:2];
      o_mem_wdata = win_wdata;
    end
  end

  // Last-grant pointer; resetting it to "host" makes core win the first conflict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_host <= 1'b1;
    end else if (host_win) begin
      last_host <= 1'b1;
    end else if (core_win) begin
      last_host <= 1'b0;
    end
  end

  // One-deep response pipeline: remembers who was granted and what to return.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid <= 1'b0;
      rsp_owner <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_read  <= 1'b0;
    end else begin
      rsp_valid <= any_gnt;
      rsp_owner <= host_win;
      rsp_err   <= any_gnt & ~win_in_range;
      rsp_read  <= mem_sel & ~win_we;
    end
  end

  // Only in-range reads carry SRAM data; writes and errors return zero.
  always_comb begin
    rsp_data      = rsp_read ? i_mem_rdata : '0;
    o_core_rvalid = rsp_valid & ~rsp_owner;
    o_host_rvalid = rsp_valid & rsp_owner;
    o_core_err    = o_core_rvalid & rsp_err;
    o_host_err    = o_host_rvalid & rsp_err;
    o_core_rdata  = o_core_rvalid ? rsp_data : '0;
    o_host_rdata  = o_host_rvalid ? rsp_data : '0;
  end

  // Byte-offset bits within a word never reach the word-addressed SRAM.
  assign unused_addr_bits = ^{i_core_addr[1:0], i_host_addr[1:0]};

`ifdef WAV_MCU_DTCM_ARB_CNT_EN
  logic [15:0] conflict_cnt;

  // Saturating count of cycles where both sides request; clear wins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      conflict_cnt <= 16'h0;
    end else if (i_cnt_clr) begin
      conflict_cnt <= 16'h0;
    end else if (i_core_req && i_host_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'h1;
    end
  end

  assign o_conflict_cnt = conflict_cnt;
`else
  logic unused_cnt_clr;

  assign o_conflict_cnt = 16'h0;
  assign unused_cnt_clr = i_cnt_clr;
`endif

endmodule

// File: tb/tb_wav_mcu_dtcm_arb.sv
// tb_wav_mcu_dtcm_arb: self-checking bench for wav_mcu_dtcm_arb.
// A behavioural model (turn flag, expected-response record, reference
// memory, conflict count) predicts every output each cycle; a table of
// vectors and a few hand-written sequences cover the directed cases.
module tb_wav_mcu_dtcm_arb;

  localparam logic [31:0] BASE  = 32'h00050000;
  localparam int          SIZE  = 65536;
  localparam int          WORDS = SIZE / 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_core_req, i_core_we;
  logic [3:0]  i_core_be;
  logic [31:0] i_core_addr, i_core_wdata;
  logic        o_core_gnt, o_core_rvalid, o_core_err;
  logic [31:0] o_core_rdata;
  logic        i_host_req, i_host_we;
  logic [3:0]  i_host_be;
  logic [31:0] i_host_addr, i_host_wdata;
  logic        o_host_gnt, o_host_rvalid, o_host_err;
  logic [31:0] o_host_rdata;
  logic        o_mem_cs, o_mem_we;
  logic [3:0]  o_mem_be;
  logic [13:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata = 32'h0;
  logic [15:0] o_conflict_cnt;
  logic        i_cnt_clr;

  int total = 0;
  int bad   = 0;

  logic [31:0] sram    [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];

  int          turn;
  bit          pend_v, pend_owner, pend_err;
  logic [31:0] pend_rdata;
  int          mcnt;
  bit          m_cgnt, m_hgnt;

  typedef struct {
    logic        creq;
    logic        cwe;
    logic [3:0]  cbe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        hreq;
    logic        hwe;
    logic [31:0] haddr;
    logic        ecg;
    logic        ehg;
    logic        ecs;
    logic        ewe;
    logic [13:0] eaddr;
  } vec_t;

  vec_t vecs [10];

  wav_mcu_dtcm_arb dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_core_req     (i_core_req),
    .i_core_we      (i_core_we),
    .i_core_be      (i_core_be),
    .i_core_addr    (i_core_addr),
    .i_core_wdata   (i_core_wdata),
    .o_core_gnt     (o_core_gnt),
    .o_core_rvalid  (o_core_rvalid),
    .o_core_rdata   (o_core_rdata),
    .o_core_err     (o_core_err),
    .i_host_req     (i_host_req),
    .i_host_we      (i_host_we),
    .i_host_be      (i_host_be),
    .i_host_addr    (i_host_addr),
    .i_host_wdata   (i_host_wdata),
    .o_host_gnt     (o_host_gnt),
    .o_host_rvalid  (o_host_rvalid),
    .o_host_rdata   (o_host_rdata),
    .o_host_err     (o_host_err),
    .o_mem_cs       (o_mem_cs),
    .o_mem_we       (o_mem_we),
    .o_mem_be       (o_mem_be),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .i_mem_rdata    (i_mem_rdata),
    .o_conflict_cnt (o_conflict_cnt),
    .i_cnt_clr      (i_cnt_clr)
  );

  always #5 i_clk = ~i_clk;

  // Simple SRAM macro model: byte-masked writes, read data the cycle after cs.
  always @(posedge i_clk) begin
    logic [31:0] w;
    if (o_mem_cs) begin
      if (o_mem_we) begin
        w = sram[o_mem_addr];
        for (int b = 0; b < 4; b++) if (o_mem_be[b]) w[8*b +: 8] = o_mem_wdata[8*b +: 8];
        sram[o_mem_addr] = w;
      end else begin
        i_mem_rdata <= sram[o_mem_addr];
      end
    end
  end

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  function automatic bit in_rng(logic [31:0] a);
    logic [63:0] a64;
    a64 = {32'h0, a};
    return (a64 >= {32'h0, BASE}) && (a64 < ({32'h0, BASE} + 64'(SIZE)));
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model step: compare this cycle's outputs, then advance the model.
  task automatic checkOutput();
    bit          cw, hw, ir, we;
    logic [31:0] a, wd, w;
    logic [3:0]  be;
    logic [51:0] exp_bus;
    int          idx;
    if (!i_rst_n) begin
      cmp("rst_gnt", {o_core_gnt, o_host_gnt}, 0);
      cmp("rst_mem", {o_mem_cs, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, 0);
      cmp("rst_rsp", {o_core_rvalid, o_core_err, o_host_rvalid, o_host_err}, 0);
      cmp("rst_rdata", {o_core_rdata, o_host_rdata}, 0);
      cmp("rst_cnt", o_conflict_cnt, 0);
      turn = 0; pend_v = 0; pend_owner = 0; pend_err = 0; pend_rdata = 0;
      mcnt = 0; m_cgnt = 0; m_hgnt = 0;
      return;
    end
    cw = 0; hw = 0;
    if (i_core_req && i_host_req) begin
      if (turn == 0) cw = 1; else hw = 1;
    end else if (i_core_req) cw = 1;
    else if (i_host_req) hw = 1;
    cmp("gnt", {o_core_gnt, o_host_gnt}, {cw, hw});
    if (hw) begin a = i_host_addr; we = i_host_we; be = i_host_be; wd = i_host_wdata; end
    else begin a = i_core_addr; we = i_core_we; be = i_core_be; wd = i_core_wdata; end
    ir  = in_rng(a);
    idx = ir ? int'((a - BASE) / 4) : 0;
    exp_bus = '0;
    if ((cw || hw) && ir) exp_bus = {1'b1, we, be, 14'(idx), wd};
    cmp("mem_bus", {o_mem_cs, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata}, exp_bus);
    cmp("rsp_flags", {o_core_rvalid, o_core_err, o_host_rvalid, o_host_err},
        {pend_v && !pend_owner, pend_v && !pend_owner && pend_err,
         pend_v && pend_owner, pend_v && pend_owner && pend_err});
    cmp("rsp_data", {o_core_rdata, o_host_rdata},
        {(pend_v && !pend_owner) ? pend_rdata : 32'h0, (pend_v && pend_owner) ? pend_rdata : 32'h0});
    cmp("cnt", o_conflict_cnt, mcnt);
    pend_v     = cw || hw;
    pend_owner = hw;
    pend_err   = pend_v && !ir;
    pend_rdata = (pend_v && ir && !we) ? ref_mem[idx] : 32'h0;
    if (pend_v && ir && we) begin
      w = ref_mem[idx];
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[idx] = w;
    end
    if (cw) turn = 1;
    if (hw) turn = 0;
`ifdef WAV_MCU_DTCM_ARB_CNT_EN
    if (i_cnt_clr) mcnt = 0;
    else if (i_core_req && i_host_req && mcnt < 65535) mcnt++;
`endif
    m_cgnt = cw; m_hgnt = hw;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic advance();
    checkOutput();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  task automatic idleInputs();
    i_core_req = 0; i_core_we = 0; i_core_be = 4'hF; i_core_addr = 0; i_core_wdata = 0;
    i_host_req = 0; i_host_we = 0; i_host_be = 4'hF; i_host_addr = 0; i_host_wdata = 0;
    i_cnt_clr  = 0;
  endtask

  task automatic doReset();
    i_rst_n = 0;
    idleInputs();
    cycle();
    cycle();
    i_rst_n = 1;
  endtask

  function automatic logic [31:0] randAddr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 6)  return BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
    if (k == 6) return BASE + 32'(SIZE) - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
    if (k == 7) return BASE - 32'($urandom_range(1, 8));
    if (k == 8) return BASE + 32'(SIZE) + 32'($urandom_range(0, 8));
    return 32'($urandom());
  endfunction

  // Random traffic that keeps a waiting request stable until it is granted.
  task automatic applyStimulus();
    if (!(i_core_req && !m_cgnt)) begin
      i_core_req   = ($urandom_range(0, 3) != 0);
      i_core_we    = 1'($urandom_range(0, 1));
      i_core_be    = 4'($urandom_range(1, 15));
      i_core_addr  = randAddr();
      i_core_wdata = 32'($urandom());
    end
    if (!(i_host_req && !m_hgnt)) begin
      i_host_req   = ($urandom_range(0, 3) != 0);
      i_host_we    = 1'($urandom_range(0, 1));
      i_host_be    = 4'($urandom_range(1, 15));
      i_host_addr  = randAddr();
      i_host_wdata = 32'($urandom());
    end
    i_cnt_clr = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end
    vecs[0] = '{1, 1, 4'hF, 32'h00050010, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 1, 1, 14'h4};
    vecs[1] = '{1, 0, 4'hF, 32'h00050010, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 14'h4};
    vecs[2] = '{1, 0, 4'hF, 32'h00050000, 32'h0,        1, 0, 32'h00050004, 0, 1, 1, 0, 14'h1};
    vecs[3] = '{1, 0, 4'hF, 32'h00050000, 32'h0,        1, 0, 32'h00050008, 1, 0, 1, 0, 14'h0};
    vecs[4] = '{0, 0, 4'hF, 32'h0,        32'h0,        1, 0, 32'h00050008, 0, 1, 1, 0, 14'h2};
    vecs[5] = '{0, 0, 4'hF, 32'h0,        32'h0,        1, 0, 32'h00060000, 0, 1, 0, 0, 14'h0};
    vecs[6] = '{1, 0, 4'hF, 32'h0004FFFC, 32'h0,        0, 0, 32'h0,        1, 0, 0, 0, 14'h0};
    vecs[7] = '{1, 1, 4'h3, 32'h0005FFFE, 32'h12345678, 0, 0, 32'h0,        1, 0, 1, 1, 14'h3FFF};
    vecs[8] = '{1, 0, 4'hF, 32'h0005FFFC, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 14'h3FFF};
    vecs[9] = '{0, 0, 4'hF, 32'h0,        32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 14'h0};

    doReset();

    // Both sides hold reads from reset: core, host, core, host.
    i_core_req = 1; i_core_addr = 32'h00050000;
    i_host_req = 1; i_host_addr = 32'h00050004;
    for (int k = 0; k < 4; k++) begin
      sample();
      cmp("rr_gnt", {o_core_gnt, o_host_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      advance();
    end
    idleInputs();
    sample();
`ifdef WAV_MCU_DTCM_ARB_CNT_EN
    cmp("rr_cnt", o_conflict_cnt, 4);
`else
    cmp("rr_cnt", o_conflict_cnt, 0);
`endif
    advance();

    // Directed vectors.
    for (int v = 0; v < 10; v++) begin
      i_core_req = vecs[v].creq; i_core_we = vecs[v].cwe; i_core_be = vecs[v].cbe;
      i_core_addr = vecs[v].caddr; i_core_wdata = vecs[v].cwdata;
      i_host_req = vecs[v].hreq; i_host_we = vecs[v].hwe; i_host_be = 4'hF;
      i_host_addr = vecs[v].haddr; i_host_wdata = 32'h0;
      sample();
      cmp("vec_gnt", {o_core_gnt, o_host_gnt}, {vecs[v].ecg, vecs[v].ehg});
      cmp("vec_mem", {o_mem_cs, o_mem_we, o_mem_addr}, {vecs[v].ecs, vecs[v].ewe, vecs[v].eaddr});
      if (v == 2) cmp("vec_rd_deadbeef", {o_core_rvalid, o_core_err, o_core_rdata}, {2'b10, 32'hDEADBEEF});
      if (v == 6) cmp("vec_oor_err", {o_host_rvalid, o_host_err, o_host_rdata}, {2'b11, 32'h0});
      advance();
    end

    // Back-to-back core reads without a bubble.
    for (int k = 0; k < 3; k++) begin
      i_core_req = 1; i_core_we = 0; i_core_addr = BASE + 32'(4 * k);
      cycle();
      cmp("b2b_rvalid", o_core_rvalid, 1);
      cmp("b2b_rdata", o_core_rdata, init_word(k));
    end
    idleInputs();
    cycle();

    // Reset asserted right after a granted host read drops the response.
    i_host_req = 1; i_host_addr = 32'h00050020;
    sample();
    cmp("rst_hgnt", o_host_gnt, 1);
    advance();
    i_rst_n = 0;
    #1;
    cmp("rst_cs_drop", {o_mem_cs, o_host_rvalid}, 0);
    advance();
    i_host_req = 0;
    cycle();
    i_rst_n = 1;
    cycle();
    i_core_req = 1; i_core_addr = 32'h00050040;
    i_host_req = 1; i_host_addr = 32'h00050044;
    sample();
    cmp("rst_ptr", {o_core_gnt, o_host_gnt}, 2'b10);
    advance();
    cycle();
    idleInputs();
    cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      applyStimulus();
      cycle();
    end
    idleInputs();
    cycle();
    cycle();

`ifdef WAV_MCU_DTCM_ARB_CNT_EN
    // Saturation and clear-during-conflict.
    doReset();
    i_core_req = 1; i_core_addr = 32'h00050000;
    i_host_req = 1; i_host_addr = 32'h00050004;
    for (int k = 0; k < 70000; k++) cycle();
    cmp("sat_cnt", o_conflict_cnt, 16'hFFFF);
    i_cnt_clr = 1;
    cycle();
    i_cnt_clr = 0;
    cmp("clr_cnt", o_conflict_cnt, 0);
    cycle();
    idleInputs();
    cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
